// File: rtl/difftest_log_pkg.sv
// Shared types and default widths for the difftest performance-event logger.
package difftest_log_pkg;

    localparam int unsigned LOG_COUNTER_W = 32;
    localparam int unsigned LOG_COREID_W  = 8;

    typedef enum logic [1:0] {
        Debug,
        Info,
        Warning,
        Error
    } LogLevel;

    // Default-width view of one report, as seen by the log collector.
    typedef struct packed {
        logic [LOG_COREID_W-1:0]  coreid;
        logic [LOG_COUNTER_W-1:0] value;
        logic [LOG_COUNTER_W-1:0] delta;
        logic                     wrap;
    } log_report_t;

endpackage

// File: rtl/log_interval_timer.sv
// Report trigger generator: fires every REPORT_INTERVAL cycles or on flush.
// REPORT_INTERVAL = 0 disables the periodic trigger, leaving flush-only.
module log_interval_timer #(
    parameter int unsigned REPORT_INTERVAL = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic trigger
);

    localparam int unsigned     IC_W     = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;
    localparam logic [IC_W-1:0] IC_LAST  = IC_W'(REPORT_INTERVAL - 1);
    localparam logic            PERIODIC = (REPORT_INTERVAL != 0);

    logic [IC_W-1:0] ic_q;
    logic [IC_W-1:0] ic_d;
    logic            at_last;

    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        at_last = PERIODIC && (ic_q == IC_LAST);
        trigger = flush || at_last;
        ic_d    = (trigger || !PERIODIC) ? '0 : ic_q + 1'b1;
    end

    // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ic_q <= '0;
        end else begin
            ic_q <= ic_d;
        end
    end

endmodule

// File: rtl/difftest_log_event.sv
// Named perf-event sampler: emits value, delta since last report and a wrap flag.
// Define DIFFTEST_LOG_EVENT_DISPLAY_EN to print every report to the simulation log.
module difftest_log_event
    import difftest_log_pkg::*;
#(
    parameter              NAME            = "event",
    parameter int unsigned COUNTER_W       = LOG_COUNTER_W,
    parameter int unsigned COREID_W        = LOG_COREID_W,
    parameter int unsigned REPORT_INTERVAL = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COREID_W-1:0]  coreid,
    input  logic [COUNTER_W-1:0] value,
    input  logic                 flush,
    output logic                 report_valid,
    output logic [COREID_W-1:0]  report_coreid,
    output logic [COUNTER_W-1:0] report_value,
    output logic [COUNTER_W-1:0] report_delta,
    output logic                 report_wrap,
    output logic [63:0]          cycle_cnt
);

    typedef struct packed {
        logic [COREID_W-1:0]  coreid;
        logic [COUNTER_W-1:0] value;
        logic [COUNTER_W-1:0] delta;
        logic                 wrap;
    } report_t;

    logic                 trigger;
    logic                 valid_q;
    logic                 valid_d;
    report_t              report_q;
    report_t              report_d;
    logic [COUNTER_W-1:0] base_q;
    logic [COUNTER_W-1:0] base_d;
    logic [63:0]          cycle_cnt_q;
    logic [63:0]          cycle_cnt_d;

    log_interval_timer #(
        .REPORT_INTERVAL (REPORT_INTERVAL)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .trigger (trigger)
    );

    always_comb begin
        valid_d     = trigger;
        report_d    = report_q;
        base_d      = base_q;
        cycle_cnt_d = cycle_cnt_q + 64'd1;
        if (trigger) begin
            // Modulo subtraction gives the correct delta across a single counter wrap.
            report_d.coreid = coreid;
            report_d.value  = value;
            report_d.delta  = value - base_q;
            report_d.wrap   = (value < base_q);
            base_d          = value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            report_q    <= '0;
            base_q      <= '0;
            cycle_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            report_q    <= report_d;
            base_q      <= base_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign report_valid  = valid_q;
    assign report_coreid = report_q.coreid;
    assign report_value  = report_q.value;
    assign report_delta  = report_q.delta;
    assign report_wrap   = report_q.wrap;
    assign cycle_cnt     = cycle_cnt_q;

`ifdef DIFFTEST_LOG_EVENT_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (valid_q) begin
            $display("[%16d] %m: %s core=%0d value=%0d delta=%0d wrap=%0d",
                     cycle_cnt_q, NAME, report_q.coreid, report_q.value,
                     report_q.delta, report_q.wrap);
        end
    end
`else
    logic unused_name;
    assign unused_name = ^NAME;
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Bench for difftest_log_event: two instances (8-bit/interval 4, 32-bit/flush-only)
// checked every cycle against a cycle-index based reference model.
module tb_difftest_log_event;

    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int A_INT = 4;
    localparam int B_INT = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    coreid_a, coreid_b;
    logic [AW-1:0] value_a;
    logic [BW-1:0] value_b;
    logic          flush_a, flush_b;

    logic          report_valid_a, report_valid_b;
    logic [7:0]    report_coreid_a, report_coreid_b;
    logic [AW-1:0] report_value_a, report_delta_a;
    logic [BW-1:0] report_value_b, report_delta_b;
    logic          report_wrap_a, report_wrap_b;
    logic [63:0]   cycle_cnt_a, cycle_cnt_b;

    always #5 clk = ~clk;

    difftest_log_event #(
        .NAME            ("evt_a"),
        .COUNTER_W       (AW),
        .COREID_W        (8),
        .REPORT_INTERVAL (A_INT)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .coreid        (coreid_a),
        .value         (value_a),
        .flush         (flush_a),
        .report_valid  (report_valid_a),
        .report_coreid (report_coreid_a),
        .report_value  (report_value_a),
        .report_delta  (report_delta_a),
        .report_wrap   (report_wrap_a),
        .cycle_cnt     (cycle_cnt_a)
    );

    difftest_log_event #(
        .NAME            ("evt_b"),
        .COUNTER_W       (BW),
        .COREID_W        (8),
        .REPORT_INTERVAL (B_INT)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .coreid        (coreid_b),
        .value         (value_b),
        .flush         (flush_b),
        .report_valid  (report_valid_b),
        .report_coreid (report_coreid_b),
        .report_value  (report_value_b),
        .report_delta  (report_delta_b),
        .report_wrap   (report_wrap_b),
        .cycle_cnt     (cycle_cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index of the current cycle since reset, index of each
    // instance's last report, and the report each instance should be showing.
    longint m_cycle;
    longint m_last  [2];
    longint m_base  [2];
    logic   e_valid [2];
    longint e_value [2];
    longint e_delta [2];
    longint e_core  [2];
    logic   e_wrap  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycle = 0;
        for (int d = 0; d < 2; d++) begin
            m_last[d]  = -1;
            m_base[d]  = 0;
            e_valid[d] = 1'b0;
            e_value[d] = 0;
            e_delta[d] = 0;
            e_core[d]  = 0;
            e_wrap[d]  = 1'b0;
        end
    endtask

    task automatic model_cycle(input int d, input int interval, input longint modulus,
                               input longint v, input logic f, input longint c);
        logic trig;
        trig = f || (interval != 0 && (m_cycle - m_last[d]) == longint'(interval));
        e_valid[d] = trig;
        if (trig) begin
            e_value[d] = v;
            e_core[d]  = c;
            e_delta[d] = (((v - m_base[d]) % modulus) + modulus) % modulus;
            e_wrap[d]  = (v < m_base[d]);
            m_base[d]  = v;
            m_last[d]  = m_cycle;
        end
    endtask

    task automatic check_all();
        check("a.valid",     64'(report_valid_a),  64'(e_valid[0]));
        check("a.value",     64'(report_value_a),  64'(e_value[0]));
        check("a.delta",     64'(report_delta_a),  64'(e_delta[0]));
        check("a.wrap",      64'(report_wrap_a),   64'(e_wrap[0]));
        check("a.coreid",    64'(report_coreid_a), 64'(e_core[0]));
        check("a.cycle_cnt", cycle_cnt_a,          64'(m_cycle));
        check("b.valid",     64'(report_valid_b),  64'(e_valid[1]));
        check("b.value",     64'(report_value_b),  64'(e_value[1]));
        check("b.delta",     64'(report_delta_b),  64'(e_delta[1]));
        check("b.wrap",      64'(report_wrap_b),   64'(e_wrap[1]));
        check("b.coreid",    64'(report_coreid_b), 64'(e_core[1]));
        check("b.cycle_cnt", cycle_cnt_b,          64'(m_cycle));
    endtask

    // One clock cycle: apply inputs mid-cycle, predict, clock, then compare.
    task automatic cycle(input logic [AW-1:0] va, input logic fa,
                         input logic [BW-1:0] vb, input logic fb);
        value_a = va;
        flush_a = fa;
        value_b = vb;
        flush_b = fb;
        model_cycle(0, A_INT, 64'd256,        longint'(va), fa, longint'(coreid_a));
        model_cycle(1, B_INT, 64'h1_0000_0000, longint'(vb), fb, longint'(coreid_b));
        m_cycle++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] seen;

        rst      = 1'b0;
        coreid_a = 8'h03;
        coreid_b = 8'h07;
        value_a  = '0;
        value_b  = '0;
        flush_a  = 1'b0;
        flush_b  = 1'b0;
        model_reset();

        // Reset state, then the first edge after release must read cycle_cnt = 1.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Periodic reports on A (value = cycle index); two single flushes on B.
        for (int i = 0; i < 12; i++) begin
            cycle(AW'(m_cycle), 1'b0, (i < 3) ? 32'd10 : 32'd25, (i == 2) || (i == 5));
            if (i == 0) check("a.first_cycle_cnt", cycle_cnt_a, 64'd1);
            if (i == 7 || i == 11) check("a.periodic_delta", 64'(report_delta_a), 64'd4);
            if (i == 2) check("b.flush_value", 64'(report_value_b), 64'd10);
            if (i == 2) check("b.flush_delta", 64'(report_delta_b), 64'd10);
            if (i == 5) check("b.flush_delta2", 64'(report_delta_b), 64'd15);
        end

        // Counter wrap on the 8-bit instance: base 250, then value 4.
        cycle(8'd250, 1'b1, 32'd25, 1'b0);
        cycle(8'd4,   1'b1, 32'd25, 1'b0);
        check("a.wrap_delta", 64'(report_delta_a), 64'd10);
        check("a.wrap_flag",  64'(report_wrap_a),  64'd1);

        // Flush colliding with the interval end: one pulse, next auto report 4 later.
        for (int k = 0; k < 8 && (m_cycle - m_last[0]) != longint'(A_INT); k++)
            cycle(AW'($urandom), 1'b0, 32'd25, 1'b0);
        cycle(8'd60, 1'b1, 32'd25, 1'b0);
        check("a.collision_pulse", 64'(report_valid_a), 64'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(AW'(8'd61 + 8'(k)), 1'b0, 32'd25, 1'b0);
            seen[k] = report_valid_a;
        end
        check("a.collision_next", 64'(seen), 64'b1000);

        // Reset asserted during a trigger cycle: the pending report is dropped.
        for (int k = 0; k < 8 && (m_cycle - m_last[0]) != longint'(A_INT); k++)
            cycle(AW'($urandom), 1'b0, 32'd25, 1'b0);
        value_a = 8'd99;
        flush_a = 1'b0;
        flush_b = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        cycle(8'd77, 1'b1, 32'd123, 1'b1);
        check("a.post_reset_delta", 64'(report_delta_a), 64'd77);
        check("b.post_reset_delta", 64'(report_delta_b), 64'd123);

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            coreid_a = 8'($urandom);
            coreid_b = 8'($urandom);
            cycle(AW'($urandom), ($urandom_range(0, 3) == 0),
                  BW'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
